// File: rtl/rf_pkg.sv
// Shared definitions for the rf_param_hs register file: handshake state
// encodings and default geometry.
package rf_pkg;

  typedef enum logic [1:0] {
    RF_IDLE    = 2'd0,
    RF_CAPTURE = 2'd1,
    RF_ACCESS  = 2'd2,
    RF_DONE    = 2'd3
  } rf_state_e;

  localparam int RF_DATA_W_DEF = 32;
  localparam int RF_DEPTH_DEF  = 32;

endpackage

// File: rtl/rf_param_hs_if.sv
// Request/response bundle between the control FSM (master) and the
// rf_param_hs register file (slave).
interface rf_param_hs_if
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W_DEF,
  parameter int DEPTH  = RF_DEPTH_DEF
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              start;
  logic [ADDR_W-1:0] read_addr_s;
  logic [ADDR_W-1:0] read_addr_t;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              write_enabled;
  logic              finish;
  logic              busy;
  logic [DATA_W-1:0] read_data_s;
  logic [DATA_W-1:0] read_data_t;

  modport master (
    output start, read_addr_s, read_addr_t, write_addr, write_data, write_enabled,
    input  finish, busy, read_data_s, read_data_t
  );

  modport slave (
    input  start, read_addr_s, read_addr_t, write_addr, write_data, write_enabled,
    output finish, busy, read_data_s, read_data_t
  );

endinterface

// File: rtl/rf_hs_ctrl.sv
// Start/finish handshake FSM for rf_param_hs: IDLE -> CAPTURE -> ACCESS -> DONE.
// finish and busy are registered copies of the next-state decode.
module rf_hs_ctrl
  import rf_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic capture_en,
  output logic access_en,
  output logic finish,
  output logic busy
);

  rf_state_e state_r;
  rf_state_e state_s;
  logic      finish_r;
  logic      busy_r;

  // Next-state and strobe decode.
  always_comb begin
    state_s    = state_r;
    capture_en = 1'b0;
    access_en  = 1'b0;
    case (state_r)
      RF_IDLE: begin
        if (start) begin
          state_s    = RF_CAPTURE;
          capture_en = 1'b1;
        end else begin
          state_s = RF_IDLE;
        end
      end
      RF_CAPTURE: state_s = RF_ACCESS;
      RF_ACCESS: begin
        access_en = 1'b1;
        state_s   = RF_DONE;
      end
      RF_DONE: begin
        // A new request only starts after start has been seen low once.
        if (start) begin
          state_s = RF_DONE;
        end else begin
          state_s = RF_IDLE;
        end
      end
      default: state_s = RF_IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= RF_IDLE;
      finish_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      finish_r <= (state_s == RF_DONE);
      busy_r   <= (state_s == RF_CAPTURE) || (state_s == RF_ACCESS);
    end
  end

  assign finish = finish_r;
  assign busy   = busy_r;

endmodule

// File: rtl/rf_param_hs.sv
// Parametrised 2-read/1-write register file with start/finish handshake; r0 reads as zero.
// Build option: define RF_BYPASS_EN to forward same-request write data to the read ports.
module rf_param_hs
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W_DEF,
  parameter int DEPTH  = RF_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  rf_param_hs_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              capture_en_s;
  logic              access_en_s;
  logic              finish_s;
  logic              busy_s;

  logic [ADDR_W-1:0] s_addr_r;
  logic [ADDR_W-1:0] t_addr_r;
  logic [ADDR_W-1:0] w_addr_r;
  logic [DATA_W-1:0] w_data_r;
  logic              w_en_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] s_out_r;
  logic [DATA_W-1:0] t_out_r;

  logic              wr_ok_s;
  logic [DATA_W-1:0] s_data_s;
  logic [DATA_W-1:0] t_data_s;

  rf_hs_ctrl u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (bus.start),
    .capture_en (capture_en_s),
    .access_en  (access_en_s),
    .finish     (finish_s),
    .busy       (busy_s)
  );

  // Request capture; inputs are ignored once the request is latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_addr_r <= ADDR_ZERO;
      t_addr_r <= ADDR_ZERO;
      w_addr_r <= ADDR_ZERO;
      w_data_r <= DATA_ZERO;
      w_en_r   <= 1'b0;
    end else if (capture_en_s) begin
      s_addr_r <= bus.read_addr_s;
      t_addr_r <= bus.read_addr_t;
      w_addr_r <= bus.write_addr;
      w_data_r <= bus.write_data;
      w_en_r   <= bus.write_enabled;
    end
  end

  // Read muxes with r0 forced to zero and optional write forwarding.
  always_comb begin
    wr_ok_s = w_en_r && (w_addr_r != ADDR_ZERO);
    if (s_addr_r == ADDR_ZERO) begin
      s_data_s = DATA_ZERO;
    end else if (BYPASS && wr_ok_s && (s_addr_r == w_addr_r)) begin
      s_data_s = w_data_r;
    end else begin
      s_data_s = mem_r[s_addr_r];
    end
    if (t_addr_r == ADDR_ZERO) begin
      t_data_s = DATA_ZERO;
    end else if (BYPASS && wr_ok_s && (t_addr_r == w_addr_r)) begin
      t_data_s = w_data_r;
    end else begin
      t_data_s = mem_r[t_addr_r];
    end
  end

  // Storage array; r0 is never written because wr_ok_s excludes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= DATA_ZERO;
      end
    end else if (access_en_s && wr_ok_s) begin
      mem_r[w_addr_r] <= w_data_r;
    end
  end

  // Read data registers, updated only on the ACCESS edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_out_r <= DATA_ZERO;
      t_out_r <= DATA_ZERO;
    end else if (access_en_s) begin
      s_out_r <= s_data_s;
      t_out_r <= t_data_s;
    end
  end

  assign bus.finish      = finish_s;
  assign bus.busy        = busy_s;
  assign bus.read_data_s = s_out_r;
  assign bus.read_data_t = t_out_r;

endmodule
